// File: rtl/attack_pkg.sv
// Shared types and default constants for the two-player attack/hit engine.
package attack_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned KEY_W = 8;
  localparam int unsigned POS_W = 32;

  localparam int unsigned DEF_STARTUP_FR  = 2;
  localparam int unsigned DEF_ACTIVE_FR   = 3;
  localparam int unsigned DEF_RECOVERY_FR = 4;
  localparam int unsigned DEF_HITSTUN_FR  = 6;
  localparam int          DEF_REACH       = 135;
  localparam int          DEF_KNOCKBACK   = 4;

  typedef enum logic [2:0] {
    IDLE,
    STARTUP,
    ACTIVE,
    RECOVERY,
    HITSTUN
  } atk_state_t;

  // Down-counter load value for a phase lasting fr frames.
  function automatic logic [CNT_W-1:0] frames_to_cnt(input int unsigned fr);
    return CNT_W'(fr - 1);
  endfunction

endpackage

// File: rtl/attack_fsm.sv
// Per-player attack FSM: key-edge detect, phase counter, landed flag and
// knockback direction latch. Instantiated once per player.
module attack_fsm
  import attack_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = 4,
  parameter logic [7:0]  KEY         = 8'h06,
  parameter int unsigned STARTUP_FR  = DEF_STARTUP_FR,
  parameter int unsigned ACTIVE_FR   = DEF_ACTIVE_FR,
  parameter int unsigned RECOVERY_FR = DEF_RECOVERY_FR,
  parameter int unsigned HITSTUN_FR  = DEF_HITSTUN_FR,
  parameter int          KNOCKBACK   = DEF_KNOCKBACK
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_KEYS*KEY_W-1:0] keycodes,
  input  logic                      hit_in,
  input  logic                      hit_dir_pos,
  input  logic                      land_in,
  input  logic                      at_min,
  input  logic                      at_max,
  output logic                      can_hit_c,
  output logic                      stun_end_c,
  output logic                      attacking,
  output logic                      active,
  output logic                      hit,
  output logic                      stun,
  output logic signed [POS_W-1:0]   kb
);

  atk_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    key_prev_q, key_prev_d;
  logic                    landed_q, landed_d;
  logic                    dir_q, dir_d;
  logic                    attacking_q, attacking_d;
  logic                    active_q, active_d;
  logic                    hit_q, hit_d;
  logic                    stun_q, stun_d;
  logic signed [POS_W-1:0] kb_q, kb_d;
  logic                    press_c;

  always_comb begin
    press_c = 1'b0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (keycodes[i*KEY_W +: KEY_W] == KEY) press_c = 1'b1;
    end
  end

  assign can_hit_c  = (state_q == ACTIVE) && !landed_q;
  assign stun_end_c = (state_q == HITSTUN) && (cnt_q == '0) && !hit_in;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    landed_d   = landed_q | land_in;
    dir_d      = dir_q;
    key_prev_d = press_c;

    case (state_q)
      IDLE: begin
        if (press_c && !key_prev_q) begin
          state_d = STARTUP;
          cnt_d   = frames_to_cnt(STARTUP_FR);
        end
      end
      STARTUP: begin
        if (cnt_q == '0) begin
          state_d  = ACTIVE;
          cnt_d    = frames_to_cnt(ACTIVE_FR);
          landed_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (cnt_q == '0) begin
          state_d = RECOVERY;
          cnt_d   = frames_to_cnt(RECOVERY_FR);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RECOVERY, HITSTUN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Being hit overrides everything, including an attack in progress.
    if (hit_in) begin
      state_d = HITSTUN;
      cnt_d   = frames_to_cnt(HITSTUN_FR);
      dir_d   = hit_dir_pos;
    end

    attacking_d = (state_d == STARTUP) || (state_d == ACTIVE) || (state_d == RECOVERY);
    active_d    = (state_d == ACTIVE);
    stun_d      = (state_d == HITSTUN);
    hit_d       = hit_in;
    kb_d        = '0;
    if (stun_d && !(dir_d ? at_max : at_min)) begin
      kb_d = dir_d ? KNOCKBACK : -KNOCKBACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_prev_q  <= 1'b0;
      landed_q    <= 1'b0;
      dir_q       <= 1'b0;
      attacking_q <= 1'b0;
      active_q    <= 1'b0;
      hit_q       <= 1'b0;
      stun_q      <= 1'b0;
      kb_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_prev_q  <= key_prev_d;
      landed_q    <= landed_d;
      dir_q       <= dir_d;
      attacking_q <= attacking_d;
      active_q    <= active_d;
      hit_q       <= hit_d;
      stun_q      <= stun_d;
      kb_q        <= kb_d;
    end
  end

  assign attacking = attacking_q;
  assign active    = active_q;
  assign hit       = hit_q;
  assign stun      = stun_q;
  assign kb        = kb_q;

endmodule

// File: rtl/attack_engine.sv
// Two-player attack/hit resolution: cross-player hit comparators and wall
// clamp around two attack_fsm instances. COMBO_COUNT_EN adds combo counters.
module attack_engine
  import attack_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = 4,
  parameter logic [7:0]  KEY_P1      = 8'h06,
  parameter logic [7:0]  KEY_P2      = 8'h11,
  parameter int unsigned STARTUP_FR  = DEF_STARTUP_FR,
  parameter int unsigned ACTIVE_FR   = DEF_ACTIVE_FR,
  parameter int unsigned RECOVERY_FR = DEF_RECOVERY_FR,
  parameter int unsigned HITSTUN_FR  = DEF_HITSTUN_FR,
  parameter int          REACH       = DEF_REACH,
  parameter int          FIST_OFS_P1 = 30,
  parameter int          FIST_OFS_P2 = 60,
  parameter int          KNOCKBACK   = DEF_KNOCKBACK,
  parameter int          X_MIN       = 0,
  parameter int          X_MAX       = 560
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [NUM_KEYS*KEY_W-1:0] keycodes,
  input  logic                      crouch_p1,
  input  logic                      crouch_p2,
  input  logic signed [POS_W-1:0]   p1_x,
  input  logic signed [POS_W-1:0]   p1_y,
  input  logic signed [POS_W-1:0]   p2_x,
  input  logic signed [POS_W-1:0]   p2_y,
  output logic                      attacking_p1,
  output logic                      attacking_p2,
  output logic                      active_p1,
  output logic                      active_p2,
  output logic                      hit_p1,
  output logic                      hit_p2,
  output logic                      stun_p1,
  output logic                      stun_p2,
  output logic signed [POS_W-1:0]   kb_p1,
  output logic signed [POS_W-1:0]   kb_p2
`ifdef COMBO_COUNT_EN
  ,
  output logic [7:0]                combo_p1,
  output logic [7:0]                combo_p2
`endif
);

  logic signed [POS_W-1:0] dx_c, dist_c;
  logic near_c;
  logic p1_can_hit_c, p2_can_hit_c;
  logic p1_hits_p2_c, p2_hits_p1_c;
  logic p1_stun_end_c, p2_stun_end_c;
  logic p1_at_min_c, p1_at_max_c, p2_at_min_c, p2_at_max_c;

  // Hit comparators run on registered FSM state and current positions.
  always_comb begin
    dx_c         = p1_x - p2_x;
    dist_c       = (dx_c < 0) ? -dx_c : dx_c;
    near_c       = dist_c < REACH;
    p1_hits_p2_c = p1_can_hit_c && near_c && (p1_y + FIST_OFS_P1 > p2_y) && !crouch_p2;
    p2_hits_p1_c = p2_can_hit_c && near_c && (p2_y + FIST_OFS_P2 > p1_y) && !crouch_p1;
    p1_at_min_c  = p1_x <= X_MIN;
    p1_at_max_c  = p1_x >= X_MAX;
    p2_at_min_c  = p2_x <= X_MIN;
    p2_at_max_c  = p2_x >= X_MAX;
  end

  attack_fsm #(
    .NUM_KEYS(NUM_KEYS), .KEY(KEY_P1),
    .STARTUP_FR(STARTUP_FR), .ACTIVE_FR(ACTIVE_FR),
    .RECOVERY_FR(RECOVERY_FR), .HITSTUN_FR(HITSTUN_FR),
    .KNOCKBACK(KNOCKBACK)
  ) u_fsm_p1 (
    .clk(frame_clk), .rst_n(Reset), .keycodes(keycodes),
    .hit_in(p2_hits_p1_c), .hit_dir_pos(p1_x >= p2_x), .land_in(p1_hits_p2_c),
    .at_min(p1_at_min_c), .at_max(p1_at_max_c),
    .can_hit_c(p1_can_hit_c), .stun_end_c(p1_stun_end_c),
    .attacking(attacking_p1), .active(active_p1), .hit(hit_p1),
    .stun(stun_p1), .kb(kb_p1)
  );

  attack_fsm #(
    .NUM_KEYS(NUM_KEYS), .KEY(KEY_P2),
    .STARTUP_FR(STARTUP_FR), .ACTIVE_FR(ACTIVE_FR),
    .RECOVERY_FR(RECOVERY_FR), .HITSTUN_FR(HITSTUN_FR),
    .KNOCKBACK(KNOCKBACK)
  ) u_fsm_p2 (
    .clk(frame_clk), .rst_n(Reset), .keycodes(keycodes),
    .hit_in(p1_hits_p2_c), .hit_dir_pos(p2_x >= p1_x), .land_in(p2_hits_p1_c),
    .at_min(p2_at_min_c), .at_max(p2_at_max_c),
    .can_hit_c(p2_can_hit_c), .stun_end_c(p2_stun_end_c),
    .attacking(attacking_p2), .active(active_p2), .hit(hit_p2),
    .stun(stun_p2), .kb(kb_p2)
  );

`ifdef COMBO_COUNT_EN
  logic [7:0] combo_p1_q, combo_p1_d, combo_p2_q, combo_p2_d;

  // Hits on an already-stunned defender extend the chain; stun expiry resets it.
  always_comb begin
    combo_p1_d = combo_p1_q;
    combo_p2_d = combo_p2_q;
    if (p1_hits_p2_c) begin
      combo_p1_d = !stun_p2 ? 8'd1 : (combo_p1_q == 8'hFF) ? 8'hFF : combo_p1_q + 8'd1;
    end else if (p2_stun_end_c) begin
      combo_p1_d = '0;
    end
    if (p2_hits_p1_c) begin
      combo_p2_d = !stun_p1 ? 8'd1 : (combo_p2_q == 8'hFF) ? 8'hFF : combo_p2_q + 8'd1;
    end else if (p1_stun_end_c) begin
      combo_p2_d = '0;
    end
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      combo_p1_q <= '0;
      combo_p2_q <= '0;
    end else begin
      combo_p1_q <= combo_p1_d;
      combo_p2_q <= combo_p2_d;
    end
  end

  assign combo_p1 = combo_p1_q;
  assign combo_p2 = combo_p2_q;
`else
  logic unused_stun_end;
  assign unused_stun_end = p1_stun_end_c ^ p2_stun_end_c;
`endif

endmodule

// File: tb/tb_attack_engine.sv
// Directed self-checking bench for attack_engine (default build).
module tb_attack_engine;

  logic               frame_clk;
  logic               Reset;
  logic [31:0]        keycodes;
  logic               crouch_p1, crouch_p2;
  logic signed [31:0] p1_x, p1_y, p2_x, p2_y;
  logic               attacking_p1, attacking_p2, active_p1, active_p2;
  logic               hit_p1, hit_p2, stun_p1, stun_p2;
  logic signed [31:0] kb_p1, kb_p2;

  int n_checks;
  int n_fail;

  attack_engine dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycodes(keycodes),
    .crouch_p1(crouch_p1), .crouch_p2(crouch_p2),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .attacking_p1(attacking_p1), .attacking_p2(attacking_p2),
    .active_p1(active_p1), .active_p2(active_p2),
    .hit_p1(hit_p1), .hit_p2(hit_p2),
    .stun_p1(stun_p1), .stun_p2(stun_p2),
    .kb_p1(kb_p1), .kb_p2(kb_p2)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one frame and settle just after the edge.
  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_att1"},  int'(attacking_p1), 0);
    check({tag, "_att2"},  int'(attacking_p2), 0);
    check({tag, "_act1"},  int'(active_p1), 0);
    check({tag, "_hit2"},  int'(hit_p2), 0);
    check({tag, "_stun2"}, int'(stun_p2), 0);
    check({tag, "_kb2"},   int'(kb_p2), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset = 1'b0;
    keycodes = '0;
    crouch_p1 = 1'b0; crouch_p2 = 1'b0;
    p1_x = 100; p2_x = 300; p1_y = 300; p2_y = 320;
    #12;
    check_all_zero("rst");
    Reset = 1'b1;

    // Async reset mid-ACTIVE
    keycodes = 32'h0006_0000;
    tick();
    keycodes = '0;
    tick();
    tick();
    check("mid_active_pre", int'(active_p1), 1);
    #3 Reset = 1'b0;
    #1 check_all_zero("async_rst");
    #2 Reset = 1'b1;
    tick();
    check("post_rst_att1", int'(attacking_p1), 0);
    check("post_rst_act1", int'(active_p1), 0);
    tick();

    // Whiff at distance 200: STARTUP 1-2, ACTIVE 3-5, RECOVERY 6-9
    p1_x = 100; p2_x = 300;
    keycodes = 32'h0006_0000;
    for (int f = 1; f <= 11; f++) begin
      tick();
      if (f == 1) keycodes = '0;
      check($sformatf("whiff_att1_f%0d", f), int'(attacking_p1), int'(f >= 1 && f <= 9));
      check($sformatf("whiff_act1_f%0d", f), int'(active_p1), int'(f >= 3 && f <= 5));
      check($sformatf("whiff_hit2_f%0d", f), int'(hit_p2), 0);
    end

    // Hit at distance 100: single pulse frame 4, stun 4-9, kb +4
    p1_x = 100; p2_x = 200;
    keycodes = 32'h0006_0000;
    for (int f = 1; f <= 12; f++) begin
      tick();
      if (f == 1) keycodes = '0;
      check($sformatf("hit_hit2_f%0d", f), int'(hit_p2), int'(f == 4));
      check($sformatf("hit_stun2_f%0d", f), int'(stun_p2), int'(f >= 4 && f <= 9));
      check($sformatf("hit_kb2_f%0d", f), kb_p2, (f >= 4 && f <= 9) ? 4 : 0);
      check($sformatf("hit_att1_f%0d", f), int'(attacking_p1), int'(f <= 9));
    end

    // Crouching defender is not hit
    crouch_p2 = 1'b1;
    keycodes = 32'h0006_0000;
    for (int f = 1; f <= 11; f++) begin
      tick();
      if (f == 1) keycodes = '0;
      check($sformatf("crouch_hit2_f%0d", f), int'(hit_p2), 0);
      check($sformatf("crouch_kb2_f%0d", f), kb_p2, 0);
    end
    crouch_p2 = 1'b0;

    // Trade: both press together, both hit in frame 4
    keycodes = 32'h0000_1106;
    for (int f = 1; f <= 11; f++) begin
      tick();
      if (f == 1) keycodes = '0;
      check($sformatf("trade_hit1_f%0d", f), int'(hit_p1), int'(f == 4));
      check($sformatf("trade_hit2_f%0d", f), int'(hit_p2), int'(f == 4));
      check($sformatf("trade_kb1_f%0d", f), kb_p1, (f >= 4 && f <= 9) ? -4 : 0);
      check($sformatf("trade_kb2_f%0d", f), kb_p2, (f >= 4 && f <= 9) ? 4 : 0);
      check($sformatf("trade_att1_f%0d", f), int'(attacking_p1), int'(f <= 3));
    end

    // Defender at right wall pushed right: no knockback; held key fires once
    p1_x = 460; p2_x = 560;
    keycodes = 32'h0006_0000;
    for (int f = 1; f <= 24; f++) begin
      tick();
      if (f == 20) keycodes = '0;
      check($sformatf("wall_att1_f%0d", f), int'(attacking_p1), int'(f <= 9));
      check($sformatf("wall_hit2_f%0d", f), int'(hit_p2), int'(f == 4));
      check($sformatf("wall_stun2_f%0d", f), int'(stun_p2), int'(f >= 4 && f <= 9));
      check($sformatf("wall_kb2_f%0d", f), kb_p2, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
